// File: rtl/note_sequencer.sv
// Song-table sequencer: fetches each reference note, listens for a sung frequency over a
// fixed window, hands the pair to the scorer and accumulates a saturating song total.
module note_sequencer #(
    parameter int NUM_NOTES   = 16,
    parameter int NOTE_CYCLES = 25_000_000,
    parameter int SCORE_WAIT  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         play,
    input  logic                         sung_valid,
    input  logic [14:0]                  sung_freq_in,
    input  logic [14:0]                  note_freq_in,
    input  logic [3:0]                   score_in,
    output logic [$clog2(NUM_NOTES)-1:0] note_addr,
    output logic [14:0]                  ref_freq_out,
    output logic [14:0]                  sung_freq_out,
    output logic                         cmp_start,
    output logic [7:0]                   total_score,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(NUM_NOTES);
    localparam int WW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
    localparam int SW = (SCORE_WAIT > 1) ? $clog2(SCORE_WAIT) : 1;
    localparam logic [AW-1:0] LAST_NOTE = AW'(NUM_NOTES - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(NOTE_CYCLES - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(SCORE_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LISTEN, S_COMPARE, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          fetch_q, fetch_d;
    logic [WW-1:0] win_q, win_d;
    logic [SW-1:0] wait_q, wait_d;
    logic [14:0]   ref_q, ref_d;
    logic [14:0]   cap_q, cap_d;
    logic [7:0]    total_q, total_d;

    logic [3:0]    score_clamped;
    logic [8:0]    score_sum;

    assign score_clamped = (score_in > 4'd10) ? 4'd10 : score_in;
    assign score_sum     = {1'b0, total_q} + {5'b0, score_clamped};

    // Disabling freezes every register in place, so any strobe state resumes intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fetch_q <= 1'b0;
            win_q   <= '0;
            wait_q  <= '0;
            ref_q   <= '0;
            cap_q   <= '0;
            total_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fetch_q <= fetch_d;
            win_q   <= win_d;
            wait_q  <= wait_d;
            ref_q   <= ref_d;
            cap_q   <= cap_d;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fetch_d = fetch_q;
        win_d   = win_q;
        wait_d  = wait_q;
        ref_d   = ref_q;
        cap_d   = cap_q;
        total_d = total_q;
        case (state_q)
            S_IDLE: begin
                if (play) begin
                    idx_d   = '0;
                    total_d = '0;
                    cap_d   = '0;
                    fetch_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Phase 0 presents the address; ROM data is valid in phase 1.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    ref_d   = note_freq_in;
                    win_d   = '0;
                    state_d = (note_freq_in == 15'd0) ? S_DONE : S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (sung_valid) cap_d = sung_freq_in;
                if (win_q == WIN_LAST) begin
                    win_d   = '0;
                    state_d = (cap_d != 15'd0) ? S_COMPARE : S_NEXT;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            S_COMPARE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    total_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    state_d = S_NEXT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_NEXT: begin
                cap_d = '0;
                if (idx_q == LAST_NOTE) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // cmp_start is a one-cycle strobe with no back-pressure: ref/sung outputs are valid
    // while it is high and stay stable until the score is sampled.
    assign cmp_start     = enable && (state_q == S_COMPARE);
    assign done          = enable && (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign note_addr     = idx_q;
    assign ref_freq_out  = ref_q;
    assign sung_freq_out = cap_q;
    assign total_score   = total_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: scripted songs, scoreboard of expected compares.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, play, sung_valid;
    logic [14:0] sung_freq_in, note_freq_in;
    logic [3:0]  score_in;
    logic [1:0]  note_addr;
    logic [14:0] ref_freq_out, sung_freq_out;
    logic        cmp_start, busy, done;
    logic [7:0]  total_score;

    int n_checks = 0;
    int n_pass   = 0;

    logic [29:0] exp_q[$];
    logic        cmp_expected  = 1'b0;
    logic        done_expected = 1'b0;

    logic [14:0] rom    [4];
    logic [14:0] sung_a [4];
    logic [14:0] sung_b [4];
    logic [3:0]  score_val;

    note_sequencer #(.NUM_NOTES(4), .NOTE_CYCLES(8), .SCORE_WAIT(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .play(play),
        .sung_valid(sung_valid), .sung_freq_in(sung_freq_in),
        .note_freq_in(note_freq_in), .score_in(score_in),
        .note_addr(note_addr), .ref_freq_out(ref_freq_out),
        .sung_freq_out(sung_freq_out), .cmp_start(cmp_start),
        .total_score(total_score), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the presented address one cycle later.
    always @(posedge clk) note_freq_in <= rom[note_addr];
    assign score_in = score_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_start || cmp_expected) check("cmp_start", cmp_start, cmp_expected);
        if (done || done_expected) check("done", done, done_expected);
        if (cmp_start) begin
            check("cmp_queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                logic [29:0] e;
                e = exp_q.pop_front();
                check("cmp_ref", ref_freq_out, e[29:15]);
                check("cmp_sung", sung_freq_out, e[14:0]);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ref"}, ref_freq_out, 0);
        check({tag, "_sung"}, sung_freq_out, 0);
        check({tag, "_total"}, total_score, 0);
        check({tag, "_addr"}, note_addr, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic finish_song(input int exp_total);
        done_expected = 1'b1;
        check("busy_at_done", busy, 1);
        check("total_at_done", total_score, exp_total);
        tick();
        done_expected = 1'b0;
        check("busy_after_done", busy, 0);
        check("total_hold", total_score, exp_total);
        repeat (2) tick();
    endtask

    // Plays one song against the scripted schedule: FETCH 2, LISTEN 8, then 1+3+1 or 1.
    task automatic run_song(input int pause_note, input int pause_cmp_note, input int abort_note);
        int          exp_total;
        logic [14:0] cap;
        logic [3:0]  sc;
        exp_total = 0;
        sc = (score_val > 4'd10) ? 4'd10 : score_val;
        play = 1'b1;
        tick();
        play = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("note_addr", note_addr, n);
            tick();
            tick();
            if (rom[n] == 15'd0) begin
                finish_song(exp_total);
                return;
            end
            check("ref_latched", ref_freq_out, rom[n]);
            cap = '0;
            for (int k = 0; k < 8; k++) begin
                if (n == pause_note && k == 4) begin
                    enable = 1'b0;
                    sung_valid = 1'b1;
                    sung_freq_in = 15'd1234;
                    repeat (5) tick();
                    enable = 1'b1;
                end
                sung_valid = 1'b0;
                if (k == 2 && sung_a[n] != 0) begin
                    sung_valid = 1'b1; sung_freq_in = sung_a[n]; cap = sung_a[n];
                end
                if (k == 7 && sung_b[n] != 0) begin
                    sung_valid = 1'b1; sung_freq_in = sung_b[n]; cap = sung_b[n];
                end
                tick();
            end
            sung_valid = 1'b0;
            if (cap != 0) begin
                exp_q.push_back({rom[n], cap});
                if (n == pause_cmp_note) begin
                    enable = 1'b0;
                    repeat (2) tick();
                    enable = 1'b1;
                end
                cmp_expected = 1'b1;
                tick();
                cmp_expected = 1'b0;
                if (n == abort_note) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check_idle_outputs("abort");
                    repeat (3) tick();
                    check("abort_stays_idle", busy, 0);
                    return;
                end
                repeat (3) tick();
                exp_total = (exp_total + sc > 255) ? 255 : exp_total + sc;
                check("total_running", total_score, exp_total);
            end
            tick();
        end
        finish_song(exp_total);
    endtask

    task automatic load_song(input int variant);
        rom    = '{15'd440, 15'd880, 15'd220, 15'd330};
        sung_a = '{15'd440, 15'd880, 15'd220, 15'd330};
        sung_b = '{15'd0, 15'd0, 15'd0, 15'd0};
        case (variant)
            2: sung_a[2] = 15'd0;
            3: rom = '{15'd440, 15'd0, 15'd0, 15'd0};
            4: begin sung_a[1] = 15'd300; sung_b[1] = 15'd440; end
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; play = 1'b0; sung_valid = 1'b0;
        sung_freq_in = '0; score_val = 4'd10;
        load_song(1);
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset");
        tick();

        load_song(1); score_val = 4'd10; run_song(-1, -1, -1);
        load_song(2); score_val = 4'd10; run_song(-1, -1, -1);
        load_song(3); score_val = 4'd10; run_song(-1, -1, -1);
        load_song(4); score_val = 4'd7;  run_song(-1, -1, -1);
        load_song(1); score_val = 4'd15; run_song(1, 2, -1);
        load_song(1); score_val = 4'd10; run_song(-1, -1, 0);
        load_song(1); score_val = 4'd10; run_song(-1, -1, -1);

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
